// File: rtl/buzzer_pkg.sv
// Shared types and constants for the alarm buzzer blocks.
// Level codes, default alarm state codes, cadence FSM states.
package buzzer_pkg;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_1    = 2'd1;
  localparam logic [1:0] LVL_2    = 2'd2;
  localparam logic [1:0] LVL_3    = 2'd3;

  localparam logic [3:0] ST_L1_DEF = 4'b0110;
  localparam logic [3:0] ST_L2_DEF = 4'b0111;
  localparam logic [3:0] ST_L3_DEF = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    BEEP,
    GAP,
    PAUSE
  } buzz_st_e;

  // Counter width for a terminal count n, never below one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buzz_tone_gen.sv
// Square-wave tone source: half-period counter plus toggle register.
// Ports: clk_base, rst_n, enable, restart, sel_hi -> tone.
module buzz_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned DIV_LO = 12500,
  parameter int unsigned DIV_HI = 6250
) (
  input  logic clk_base,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  input  logic sel_hi,
  output logic tone
);

  localparam int DMAX = (DIV_LO > DIV_HI) ? DIV_LO : DIV_HI;
  localparam int CW   = cw(DMAX);

  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;

  assign lim = sel_hi ? CW'(DIV_HI - 1) : CW'(DIV_LO - 1);

  // Restart starts a high half-cycle; disabled means silent.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tone <= 1'b1;
    end else if (!enable) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == lim) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/buzzer_pattern_gen.sv
// Three-level alarm buzzer: level decode, beep cadence FSM, ack/mute.
// Ports: clk_base, rst_n, state_in, ack_in -> buzz/active/muted/level.
module buzzer_pattern_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned STATE_W     = 4,
  parameter logic [STATE_W-1:0] ST_L1 = ST_L1_DEF,
  parameter logic [STATE_W-1:0] ST_L2 = ST_L2_DEF,
  parameter logic [STATE_W-1:0] ST_L3 = ST_L3_DEF,
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned TONE_DIV_LO = 12500,
  parameter int unsigned TONE_DIV_HI = 6250,
  parameter int unsigned BEEP_TICKS  = 10,
  parameter int unsigned GAP_TICKS   = 10,
  parameter int unsigned PAUSE_TICKS = 50
) (
  input  logic               clk_base,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state_in,
  input  logic               ack_in,
  output logic               buzz_out,
  output logic               active_out,
  output logic               muted_out,
  output logic [1:0]         level_out
);

  localparam int PW = cw(TICK_DIV);
  localparam int T1 = (BEEP_TICKS > GAP_TICKS) ?
                      BEEP_TICKS : GAP_TICKS;
  localparam int TM = (T1 > PAUSE_TICKS) ? T1 : PAUSE_TICKS;
  localparam int HW = cw(TM);

  buzz_st_e      st, st_nxt;
  logic [1:0]    level_d, level_q, lvl_prev;
  logic [1:0]    ack_lvl, beep_cnt;
  logic          mute, active_q;
  logic [PW-1:0] pre;
  logic [HW-1:0] phase, ph_lim;
  logic          tick, end_ph, lvl_chg;
  logic          trans, tone_rst, tone;

  always_comb begin
    level_d = LVL_NONE;
    unique case (1'b1)
      (state_in == ST_L1): level_d = LVL_1;
      (state_in == ST_L2): level_d = LVL_2;
      (state_in == ST_L3): level_d = LVL_3;
      default:             level_d = LVL_NONE;
    endcase
  end

  always_comb begin
    ph_lim = '0;
    case (st)
      BEEP:    ph_lim = HW'(BEEP_TICKS - 1);
      GAP:     ph_lim = HW'(GAP_TICKS - 1);
      PAUSE:   ph_lim = HW'(PAUSE_TICKS - 1);
      default: ph_lim = '0;
    endcase
  end

  assign tick   = (pre == PW'(TICK_DIV - 1));
  assign end_ph = tick && (phase == ph_lim);

  // A level swap while sounding restarts the burst from its first beep.
  always_comb begin
    st_nxt  = st;
    lvl_chg = 1'b0;
    if (level_q == LVL_NONE || mute) begin
      st_nxt = IDLE;
    end else if (st != IDLE && level_q != lvl_prev) begin
      st_nxt  = BEEP;
      lvl_chg = 1'b1;
    end else begin
      case (st)
        IDLE: st_nxt = BEEP;
        BEEP: if (end_ph)
          st_nxt = ({1'b0, beep_cnt} + 3'd1 < {1'b0, level_q}) ?
                   GAP : PAUSE;
        GAP:     if (end_ph) st_nxt = BEEP;
        PAUSE:   if (end_ph) st_nxt = BEEP;
        default: st_nxt = IDLE;
      endcase
    end
  end

  assign trans    = (st_nxt != st) || lvl_chg;
  assign tone_rst = (st_nxt == BEEP) && trans;

  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      level_q  <= LVL_NONE;
      lvl_prev <= LVL_NONE;
      ack_lvl  <= LVL_NONE;
      mute     <= 1'b0;
      active_q <= 1'b0;
      pre      <= '0;
      phase    <= '0;
      beep_cnt <= '0;
    end else begin
      level_q  <= level_d;
      lvl_prev <= level_q;
      st       <= st_nxt;
      active_q <= (st_nxt != IDLE);

      // An ack arriving with an escalation is dropped.
      if (level_q == LVL_NONE) begin
        mute <= 1'b0;
      end else if (mute && level_q > ack_lvl) begin
        mute <= 1'b0;
      end else if (ack_in && level_d <= level_q) begin
        mute    <= 1'b1;
        ack_lvl <= level_q;
      end

      if (trans || st == IDLE) begin
        pre   <= '0;
        phase <= '0;
      end else if (tick) begin
        pre   <= '0;
        phase <= phase + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end

      if (lvl_chg || st == IDLE || (st == PAUSE && trans))
        beep_cnt <= '0;
      else if (st == BEEP && end_ph)
        beep_cnt <= beep_cnt + 1'b1;
    end
  end

  buzz_tone_gen #(
    .DIV_LO (TONE_DIV_LO),
    .DIV_HI (TONE_DIV_HI)
  ) u_tone (
    .clk_base (clk_base),
    .rst_n    (rst_n),
    .enable   (st_nxt == BEEP),
    .restart  (tone_rst),
    .sel_hi   (level_q == LVL_3),
    .tone     (tone)
  );

  assign buzz_out   = tone;
  assign active_out = active_q;
  assign muted_out  = mute;
  assign level_out  = level_q;

endmodule
